// File: rtl/theta_pkg.sv
// Shared constants, slew-state type and angle conversion for theta_setpoint_ctrl.
package theta_pkg;

   localparam int unsigned DEG_MIN     = 90;
   localparam int unsigned DEG_MAX     = 180;
   localparam int unsigned DEG_RESET   = 180;
   localparam int unsigned K_DEG2THETA = 1787;
   localparam int unsigned K_SHIFT     = 10;

   typedef enum logic [1:0] {IDLE, UP, DOWN} slew_state_e;

   // Degrees to controller units: (deg * 1787) >> 10, 19-bit product, zero-extended.
   function automatic logic signed [31:0] deg_to_theta(input logic [7:0] deg);
      logic [18:0] prod;
      prod = 19'(deg) * 19'(K_DEG2THETA);
      return $signed({13'd0, prod >> K_SHIFT});
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low button conditioner: 2-flop synchronizer, stable-sample counter,
// debounced level and a 1-cycle pulse on the debounced press (1->0) edge.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_n,
   output logic press
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d, level_dly_q;
   logic            press_q;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Count consecutive samples that disagree with the debounced level; flip on the last one.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntLast) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchronizer, debounce state and press-edge register; released (1) after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         level_q     <= 1'b1;
         level_dly_q <= 1'b1;
         cnt_q       <= '0;
         press_q     <= 1'b0;
      end else begin
         sync1_q     <= raw_n;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         cnt_q       <= cnt_d;
         press_q     <= level_dly_q & ~level_q;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/theta_setpoint_ctrl.sv
// Theta setpoint controller: debounced buttons adjust a saturated target angle,
// the applied angle follows it and is converted to the signed theta word.
// Build option: define THETA_SLEW_EN to rate-limit the applied angle (slew FSM + divider);
// without it the applied angle follows the target with one cycle of latency.
module theta_setpoint_ctrl
   import theta_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned RAMP_DIV        = 100_000,
   parameter int unsigned DEG_STEP        = 5
) (
   input  logic               i_clock,
   input  logic               i_RESET,
   input  logic [3:0]         i_button,
   input  logic               i_enable,
   output logic signed [31:0] o_theta,
   output logic [7:0]         o_deg,
   output logic [7:0]         o_target,
   output logic               o_busy
);

   logic               press_rst, press_dec, press_inc;
   logic [7:0]         target_q, target_d;
   logic [7:0]         deg_q;
   logic signed [31:0] theta_q;
   logic [8:0]         tgt_inc;
   logic [7:0]         tgt_dec;
   logic               unused_btn;

   assign unused_btn = i_button[1];

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
      .clock (i_clock),
      .reset (i_RESET),
      .raw_n (i_button[0]),
      .press (press_rst)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
      .clock (i_clock),
      .reset (i_RESET),
      .raw_n (i_button[2]),
      .press (press_dec)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clock (i_clock),
      .reset (i_RESET),
      .raw_n (i_button[3]),
      .press (press_inc)
   );

   // Target update: reset beats increase beats decrease; results clamp to [DEG_MIN, DEG_MAX].
   always_comb begin
      tgt_inc  = {1'b0, target_q} + 9'(DEG_STEP);
      tgt_dec  = target_q - 8'(DEG_STEP);
      target_d = target_q;
      if (press_rst) begin
         target_d = 8'(DEG_RESET);
      end else if (press_inc) begin
         target_d = (tgt_inc > 9'(DEG_MAX)) ? 8'(DEG_MAX) : tgt_inc[7:0];
      end else if (press_dec) begin
         // Compare before subtracting so the clamp never sees an underflowed value.
         target_d = ({1'b0, target_q} < (9'(DEG_MIN) + 9'(DEG_STEP))) ? 8'(DEG_MIN) : tgt_dec;
      end
   end

   // Target and theta registers; theta lags the applied angle by one cycle.
   always_ff @(posedge i_clock) begin
      if (i_RESET) begin
         target_q <= 8'(DEG_RESET);
         theta_q  <= deg_to_theta(8'(DEG_RESET));
      end else begin
         target_q <= target_d;
         theta_q  <= deg_to_theta(deg_q);
      end
   end

`ifdef THETA_SLEW_EN
   localparam int unsigned DivW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(RAMP_DIV - 1);

   slew_state_e     state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [7:0]      deg_d;

   // Slew state register.
   always_ff @(posedge i_clock) begin
      if (i_RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: direction is re-chosen every cycle from the registered angles.
   always_comb begin
      state_d = state_q;
      if (!i_enable) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, UP, DOWN: begin
               if (deg_q < target_q) begin
                  state_d = UP;
               end else if (deg_q > target_q) begin
                  state_d = DOWN;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Divider and angle step; a step only happens if the current direction still points at target.
   always_comb begin
      div_d = '0;
      deg_d = deg_q;
      if (!i_enable) begin
         deg_d = target_q;
      end else if ((state_q == UP || state_q == DOWN) && (deg_q != target_q)) begin
         if (div_q == DivLast) begin
            div_d = '0;
            if (state_q == UP && deg_q < target_q) begin
               deg_d = deg_q + 8'd1;
            end else if (state_q == DOWN && deg_q > target_q) begin
               deg_d = deg_q - 8'd1;
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   // Divider and applied-angle registers.
   always_ff @(posedge i_clock) begin
      if (i_RESET) begin
         div_q <= '0;
         deg_q <= 8'(DEG_RESET);
      end else begin
         div_q <= div_d;
         deg_q <= deg_d;
      end
   end

   assign o_busy = (deg_q != target_q);
`else
   logic unused_cfg;

   assign unused_cfg = ^{RAMP_DIV, i_enable};

   // Applied angle follows the target directly.
   always_ff @(posedge i_clock) begin
      if (i_RESET) begin
         deg_q <= 8'(DEG_RESET);
      end else begin
         deg_q <= target_q;
      end
   end

   assign o_busy = 1'b0;
`endif

   assign o_deg    = deg_q;
   assign o_target = target_q;
   assign o_theta  = theta_q;

endmodule

// File: tb/tb_theta_setpoint_ctrl.sv
// Bench for theta_setpoint_ctrl: behavioural model checked every cycle, plus literal checkpoints.
module tb_theta_setpoint_ctrl;

   localparam int DB   = 4;
   localparam int RD   = 3;
   localparam int STEP = 5;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [3:0]         btn = 4'hF;
   logic               en  = 1'b0;
   logic signed [31:0] theta;
   logic [7:0]         deg, target;
   logic               busy;

   theta_setpoint_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .RAMP_DIV        (RD),
      .DEG_STEP        (STEP)
   ) dut (
      .i_clock  (clk),
      .i_RESET  (rst),
      .i_button (btn),
      .i_enable (en),
      .o_theta  (theta),
      .o_deg    (deg),
      .o_target (target),
      .o_busy   (busy)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Button index 0 = reset (btn0), 1 = decrease (btn2), 2 = increase (btn3).
   int m_hist[3][DB+2];   // raw samples, [0] newest
   bit m_lvl[3];
   bit m_fell[3];
   bit m_press[3];
   int m_target, m_deg, m_theta;
   bit m_moving;
   int m_dir, m_timer;

   function automatic int theta_of(input int d);
      return (d * 1787) / 1024;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < DB + 2; j++) m_hist[i][j] = 1;
         m_lvl[i]   = 1'b1;
         m_fell[i]  = 1'b0;
         m_press[i] = 1'b0;
      end
      m_target = 180;
      m_deg    = 180;
      m_theta  = 314;
      m_moving = 1'b0;
      m_dir    = 0;
      m_timer  = 0;
   endtask

   task automatic model_step(input logic [3:0] b, input logic e);
      int nt, nd;
      int raw[3];
      bit all_diff;
      raw[0] = int'(b[0]);
      raw[1] = int'(b[2]);
      raw[2] = int'(b[3]);
      // target from the press pulses visible before this edge
      nt = m_target;
      if (m_press[0])      nt = 180;
      else if (m_press[2]) nt = (m_target + STEP > 180) ? 180 : m_target + STEP;
      else if (m_press[1]) nt = (m_target - STEP < 90) ? 90 : m_target - STEP;
      m_theta = theta_of(m_deg);
`ifdef THETA_SLEW_EN
      nd = m_deg;
      if (!e) begin
         nd       = m_target;
         m_moving = 1'b0;
         m_timer  = 0;
      end else if (!m_moving) begin
         if (m_deg != m_target) begin
            m_moving = 1'b1;
            m_dir    = (m_target > m_deg) ? 1 : -1;
         end
         m_timer = 0;
      end else if (m_deg == m_target) begin
         m_moving = 1'b0;
         m_timer  = 0;
      end else begin
         if (m_timer == RD - 1) begin
            m_timer = 0;
            if ((m_dir > 0) == (m_target > m_deg)) nd = m_deg + m_dir;
         end else begin
            m_timer++;
         end
         m_dir = (m_target > m_deg) ? 1 : -1;
      end
`else
      nd = m_target;
      if (e) nd = m_target;
`endif
      // a press pulse appears one edge after the debounced level falls
      for (int i = 0; i < 3; i++) begin
         m_press[i] = m_fell[i];
         for (int j = DB + 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
         m_hist[i][0] = raw[i];
         all_diff = 1'b1;
         for (int j = 2; j < DB + 2; j++) if (m_hist[i][j] == int'(m_lvl[i])) all_diff = 1'b0;
         m_fell[i] = 1'b0;
         if (all_diff) begin
            m_fell[i] = m_lvl[i];
            m_lvl[i]  = !m_lvl[i];
         end
      end
      m_target = nt;
      m_deg    = nd;
   endtask

   // Model advances on each edge from the inputs held there; outputs compared 1 time unit later.
   always @(posedge clk) begin
      logic [3:0] b_s;
      logic       r_s, e_s;
      b_s = btn;
      r_s = rst;
      e_s = en;
      if (r_s) model_reset();
      else model_step(b_s, e_s);
      #1;
      check("model_deg", int'(deg), m_deg);
      check("model_target", int'(target), m_target);
      check("model_theta", int'(theta), m_theta);
`ifdef THETA_SLEW_EN
      check("model_busy", int'(busy), int'(m_deg != m_target));
`else
      check("model_busy", int'(busy), 0);
`endif
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] mask, input int low, input int gap);
      @(negedge clk);
      btn = 4'hF & ~mask;
      cycles(low);
      btn = 4'hF;
      cycles(gap);
   endtask

   initial begin
      model_reset();
      cycles(3);
      rst = 1'b0;

      // 1: reset state after idling
      cycles(20);
      check("reset_deg", int'(deg), 180);
      check("reset_target", int'(target), 180);
      check("reset_theta", int'(theta), 314);
      check("reset_busy", int'(busy), 0);

      // 2: one decrease press, then settle
      en = 1'b1;
      press(4'b0100, 10, 2);
      check("dec_target", int'(target), 175);
`ifdef THETA_SLEW_EN
      check("dec_busy", int'(busy), 1);
`endif
      cycles(30);
      check("dec_deg", int'(deg), 175);
      check("dec_theta", int'(theta), 305);
      check("dec_settled", int'(busy), 0);

      // 3: saturate low, then one increase
      repeat (25) press(4'b0100, 6, 8);
      check("sat_low", int'(target), 90);
      press(4'b1000, 6, 8);
      check("inc_from_min", int'(target), 95);

      // 4: short bounces are rejected, a held press gives exactly one step
      repeat (4) begin
         btn[3] = 1'b0;
         cycles(3);
         btn[3] = 1'b1;
         cycles(3);
      end
      cycles(8);
      check("bounce_ignored", int'(target), 95);
      press(4'b1000, 6, 8);
      check("held_one_event", int'(target), 100);

      // 5: reset and decrease together from 120
      repeat (4) press(4'b1000, 6, 8);
      check("reach_120", int'(target), 120);
      press(4'b0101, 6, 8);
      check("reset_wins", int'(target), 180);

      // 6: enable low snaps the angle; reset mid-ramp
      repeat (6) press(4'b0100, 6, 8);
      check("reach_150", int'(target), 150);
      en = 1'b0;
      cycles(1);
      check("disable_deg", int'(deg), 150);
      check("disable_busy", int'(busy), 0);
      en = 1'b1;
      press(4'b0100, 6, 6);
      rst = 1'b1;
      cycles(1);
      check("midramp_deg", int'(deg), 180);
      check("midramp_target", int'(target), 180);
      check("midramp_theta", int'(theta), 314);
      check("midramp_busy", int'(busy), 0);
      rst = 1'b0;

      // random phase: presses with bounces, overlaps, enable toggles and resets
      repeat (400) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 4) begin
            rst = 1'b1;
            cycles(1);
            rst = 1'b0;
         end else if (r < 15) begin
            en = ~en;
            cycles(int'($urandom_range(1, 6)));
         end else begin
            logic [3:0] m;
            m = 4'($urandom_range(0, 15));
            press(m, int'($urandom_range(1, 10)), int'($urandom_range(0, 10)));
         end
      end
      cycles(50);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
